// File: rtl/bmp_frame_writer.sv
// rtl/bmp_frame_writer.sv - decoder pixel stream to linear frame-memory write requests
module bmp_frame_writer #(
    parameter int          ADDR_W     = 20,
    parameter int          FIFO_DEPTH = 16,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              decode_val,
    input  logic [15:0]       decode_Xaddress,
    input  logic [15:0]       decode_Yaddress,
    input  logic [23:0]       decode_data,
    input  logic              decod_done,
    input  logic [15:0]       img_width,
    input  logic [15:0]       img_height,
    input  logic              flip_v,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [23:0]       mem_wr_data,
    input  logic              mem_wr_ready,
    output logic              frame_done,
    output logic              overflow,
    output logic              oor_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, WAITLO} state_t;

    state_t      state;
    logic [15:0] width_q;
    logic [15:0] height_q;
    logic        flip_q;

    logic              s1_valid;
    logic              s1_oor;
    logic [ADDR_W-1:0] s1_addr;
    logic [23:0]       s1_data;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [23:0]       fifo_data [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;

    logic              accept;
    logic              start;
    logic [15:0]       eff_w;
    logic [15:0]       eff_h;
    logic              eff_flip;
    logic [15:0]       row;
    logic              oor_calc;
    logic [31:0]       sum;
    logic              push_req;
    logic              push;
    logic              pop;

    // The first pixel of a frame is computed with the live geometry, since it is latched that same cycle.
    assign start    = (state == IDLE) && decode_val;
    assign accept   = decode_val && ((state == IDLE) || (state == RUN) || (state == DRAIN));
    assign eff_w    = (state == IDLE) ? img_width  : width_q;
    assign eff_h    = (state == IDLE) ? img_height : height_q;
    assign eff_flip = (state == IDLE) ? flip_v     : flip_q;

    // Row selection, range check and linear address for the incoming pixel.
    always_comb begin
        row      = eff_flip ? (eff_h - 16'd1 - decode_Yaddress) : decode_Yaddress;
        oor_calc = (decode_Xaddress >= eff_w) || (decode_Yaddress >= eff_h);
        sum      = ({16'd0, row} * {16'd0, eff_w}) + {16'd0, decode_Xaddress} + 32'(BASE_ADDR);
    end

    assign push_req   = s1_valid && !s1_oor;
    assign pop        = (count != '0) && mem_wr_ready;
    assign push       = push_req && ((count != CW'(FIFO_DEPTH)) || pop);
    assign mem_wr_req = (count != '0);
    assign mem_wr_addr = mem_wr_req ? fifo_addr[rd_ptr] : '0;
    assign mem_wr_data = mem_wr_req ? fifo_data[rd_ptr] : '0;

    // Frame sequencing, geometry latch, done pulse and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            width_q    <= '0;
            height_q   <= '0;
            flip_q     <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            oor_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (decode_val) begin
                    state    <= RUN;
                    width_q  <= img_width;
                    height_q <= img_height;
                    flip_q   <= flip_v;
                end
                RUN:    if (decod_done) state <= DRAIN;
                DRAIN:  if (!s1_valid && (count == '0)) begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                end
                DONE:   state <= WAITLO;
                WAITLO: if (!decod_done) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (start) begin
                overflow <= 1'b0;
                oor_err  <= 1'b0;
            end else begin
                if (push_req && !push) overflow <= 1'b1;
                if (s1_valid && s1_oor) oor_err <= 1'b1;
            end
        end
    end

    // Stage 1: register the computed address, range verdict and pixel data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_oor   <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_oor  <= oor_calc;
                s1_addr <= sum[ADDR_W-1:0];
                s1_data <= decode_data;
            end
        end
    end

    // FIFO bookkeeping; a push into a full FIFO is allowed when the head leaves the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= s1_addr;
            fifo_data[wr_ptr] <= s1_data;
        end
    end

endmodule

// File: tb/tb_bmp_frame_writer.sv
// tb/tb_bmp_frame_writer.sv - scoreboard bench for bmp_frame_writer
module tb_bmp_frame_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        decode_val = 1'b0;
    logic [15:0] decode_Xaddress = '0;
    logic [15:0] decode_Yaddress = '0;
    logic [23:0] decode_data = '0;
    logic        decod_done = 1'b0;
    logic [15:0] img_width = 16'd4;
    logic [15:0] img_height = 16'd3;
    logic        flip_v = 1'b0;
    logic        mem_wr_req;
    logic [19:0] mem_wr_addr;
    logic [23:0] mem_wr_data;
    logic        mem_wr_ready = 1'b1;
    logic        frame_done;
    logic        overflow;
    logic        oor_err;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int wr_cnt = 0;
    logic [23:0] next_data = 24'hA50000;
    logic [43:0] sb [$];

    bmp_frame_writer dut (
        .clk(clk), .rst_n(rst_n), .decode_val(decode_val),
        .decode_Xaddress(decode_Xaddress), .decode_Yaddress(decode_Yaddress),
        .decode_data(decode_data), .decod_done(decod_done),
        .img_width(img_width), .img_height(img_height), .flip_v(flip_v),
        .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_wr_ready(mem_wr_ready), .frame_done(frame_done),
        .overflow(overflow), .oor_err(oor_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Transfers happen at the next posedge; sample them mid-cycle.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (rst_n && mem_wr_req && mem_wr_ready) begin
            logic [43:0] e;
            wr_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_write", {24'd0, mem_wr_addr, mem_wr_data}, 64'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(mem_wr_addr), 64'(e[43:24]));
                chk("wr_data", 64'(mem_wr_data), 64'(e[23:0]));
            end
        end
    end

    function automatic int exp_addr(input int x, input int y, input bit flip, input int w);
        exp_addr = flip ? ((int'(img_height) - 1 - y) * w + x) : (y * w + x);
    endfunction

    task automatic pix(input int x, input int y, input bit expect_wr);
        int a;
        decode_val = 1'b1;
        decode_Xaddress = x[15:0];
        decode_Yaddress = y[15:0];
        decode_data = next_data;
        if (expect_wr) begin
            a = exp_addr(x, y, flip_v, int'(img_width));
            sb.push_back({a[19:0], next_data});
        end
        next_data = next_data + 24'h000101;
        @(posedge clk); #1;
        decode_val = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic end_frame(input string tag);
        int fd0;
        bit seen;
        fd0 = fd_cnt;
        seen = 1'b0;
        decod_done = 1'b1;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        cycles(4);
        chk({tag, "_done_pulses"}, 64'(fd_cnt - fd0), 64'd1);
        chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
        decod_done = 1'b0;
        cycles(3);
    endtask

    task automatic wait_sb_empty(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int w0;
        cycles(2);
        @(negedge clk);
        chk("rst_req", 64'(mem_wr_req), 64'd0);
        chk("rst_addr", 64'(mem_wr_addr), 64'd0);
        chk("rst_done", 64'(frame_done), 64'd0);
        chk("rst_flags", 64'({overflow, oor_err}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(2);

        // Raster 4x3 frame, no flip
        img_width = 16'd4; img_height = 16'd3; flip_v = 1'b0; mem_wr_ready = 1'b1;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) pix(x, y, 1'b1);
        end_frame("raster");

        // Same frame, vertical flip
        flip_v = 1'b1;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) pix(x, y, 1'b1);
        end_frame("flip");
        flip_v = 1'b0;

        // Overflow: 20 pixels while memory stalls, only 16 survive
        img_width = 16'd4; img_height = 16'd8; mem_wr_ready = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 20; i++) pix(i % 4, i / 4, i < 16);
        cycles(30);
        @(negedge clk);
        chk("ovf_req_held", 64'(mem_wr_req), 64'd1);
        chk("ovf_head_addr", 64'(mem_wr_addr), 64'd0);
        chk("ovf_head_data", 64'(mem_wr_data), 64'(sb[0][23:0]));
        chk("ovf_flag", 64'(overflow), 64'd1);
        @(posedge clk); #1;
        mem_wr_ready = 1'b1;
        wait_sb_empty(60);
        cycles(3);
        chk("ovf_write_count", 64'(wr_cnt - w0), 64'd16);
        end_frame("ovf");

        // Out-of-range pixel dropped, others still written
        img_width = 16'd4; img_height = 16'd3;
        pix(0, 0, 1'b1);
        pix(5, 0, 1'b0);
        pix(1, 0, 1'b1);
        pix(3, 2, 1'b1);
        cycles(4);
        chk("oor_flag", 64'(oor_err), 64'd1);
        chk("oor_ovf_cleared", 64'(overflow), 64'd0);
        end_frame("oor");

        // Full FIFO with simultaneous pop and push
        img_width = 16'd4; img_height = 16'd8; mem_wr_ready = 1'b0;
        for (int i = 0; i < 16; i++) pix(i % 4, i / 4, 1'b1);
        cycles(3);
        pix(0, 4, 1'b1);
        mem_wr_ready = 1'b1;
        wait_sb_empty(60);
        cycles(2);
        chk("full_pop_push_ovf", 64'(overflow), 64'd0);
        chk("full_pop_push_oor", 64'(oor_err), 64'd0);
        end_frame("fullpp");

        // Reset mid-frame with 5 pixels queued
        img_width = 16'd4; img_height = 16'd3; mem_wr_ready = 1'b0;
        for (int i = 0; i < 5; i++) pix(i % 4, i / 4, 1'b0);
        cycles(3);
        w0 = fd_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_req", 64'(mem_wr_req), 64'd0);
        chk("midrst_done", 64'(frame_done), 64'd0);
        cycles(2);
        rst_n = 1'b1;
        mem_wr_ready = 1'b1;
        cycles(5);
        chk("midrst_no_done", 64'(fd_cnt - w0), 64'd0);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++) pix(x, y, 1'b1);
        end_frame("post_rst");
        chk("post_rst_flags", 64'({overflow, oor_err}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
